// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero/ready masking plus optional write forwarding (REGFILE_WRITE_BYPASS_EN).
// Latency: 0 cycles, purely combinational from array and write inputs.
// Backpressure: none; output is forced to 0 while the array is not ready.
module regfile_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  ready,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] array_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] data
);

    localparam bit ZR = (ZERO_REG != 0);

`ifdef REGFILE_WRITE_BYPASS_EN
    always_comb begin
        data = array_data;
        if (write_en && (addr == write_addr))
            data = write_data;
        // Zero register and not-ready masking win over forwarding.
        if (!ready || (ZR && (addr == '0)))
            data = '0;
    end
`else
    logic bypass_unused;
    assign bypass_unused = ^{write_en, write_addr, write_data};

    always_comb begin
        data = array_data;
        if (!ready || (ZR && (addr == '0)))
            data = '0;
    end
`endif

endmodule

// File: rtl/register_file_mp.sv
// Single-write, NUM_READ-read register file with post-reset clear sequencer; REGFILE_WRITE_BYPASS_EN adds write forwarding.
// Latency: reads combinational, writes on the rising edge; ready rises DEPTH cycles after rst falls.
// Backpressure: writes while not ready (or to the zero register) are dropped and flagged on write_drop.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           write_en,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic                           ready,
    output logic                           write_drop
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  zero_hit;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign zero_hit = ZR && (write_addr == '0);
    // While rst is held the counter is being forced to 0, so clear entry 0.
    assign clr_addr = rst ? '0 : clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            clr_cnt    <= '0;
            ready      <= 1'b0;
            write_drop <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt    <= clr_cnt + 1'b1;
                    write_drop <= write_en;
                    if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    write_drop <= write_en && zero_hit;
                end
            endcase
        end
    end

    // Storage carries no reset; the sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_INIT))
            mem[clr_addr] <= '0;
        else if (write_en && !zero_hit)
            mem[write_addr] <= write_data;
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        assign addr = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG)
        ) u_rd (
            .ready      (ready),
            .addr       (addr),
            .array_data (mem[addr]),
            .write_en   (write_en),
            .write_addr (write_addr),
            .write_data (write_data),
            .data       (read_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: default instance plus a ZERO_REG=0, NUM_READ=4 instance sharing write/reset inputs.
// Expected values come from a hand-filled vector table pushed through a scoreboard queue.
module tb_register_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            write_en;
    logic [AW-1:0]   write_addr;
    logic [DW-1:0]   write_data;
    logic [2*AW-1:0] read_addr;
    logic [2*DW-1:0] read_data;
    logic            ready;
    logic            write_drop;
    logic [4*AW-1:0] read_addr4;
    logic [4*DW-1:0] read_data4;
    logic            ready4;
    logic            write_drop4;

    always #5 clk = ~clk;

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .read_addr(read_addr), .read_data(read_data),
        .ready(ready), .write_drop(write_drop)
    );

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(4), .ZERO_REG(0)) dut4 (
        .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .read_addr(read_addr4), .read_data(read_data4),
        .ready(ready4), .write_drop(write_drop4)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra4;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [DW-1:0] e4;
        logic          edrop;
        logic          edrop4;
    } vec_t;

    localparam int NV = 9;
    vec_t tv [NV];
    vec_t sb [$];
    vec_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    int   n;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            read_addr  = {AW'(a), AW'(a)};
            read_addr4 = {4{AW'(a)}};
            #1;
            chk({tag, "_p0"}, read_data[0 +: DW], '0);
            chk({tag, "_p1"}, read_data[DW +: DW], '0);
            chk({tag, "_q0"}, read_data4[0 +: DW], '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           we   wa     wd            ra0    ra1    ra4    e0     e1                        e4                             drop  drop4
        tv[0] = '{1'b1, 5'd5,  32'hAA,       5'd0,  5'd5,  5'd5,  32'h0, BYP ? 32'hAA : 32'h0,     BYP ? 32'hAA : 32'h0,          1'b0, 1'b0};
        tv[1] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  5'd5,  32'h0, 32'hAA,                   32'hAA,                        1'b0, 1'b0};
        tv[2] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd5,  5'd0,  32'h0, 32'hAA,                   BYP ? 32'hDEADBEEF : 32'h0,    1'b1, 1'b0};
        tv[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0, 32'h0,                    32'hDEADBEEF,                  1'b0, 1'b0};
        tv[4] = '{1'b1, 5'd7,  32'h9,        5'd7,  5'd7,  5'd7,  BYP ? 32'h9 : 32'h0, BYP ? 32'h9 : 32'h0, BYP ? 32'h9 : 32'h0,  1'b0, 1'b0};
        tv[5] = '{1'b1, 5'd7,  32'h1234,     5'd7,  5'd7,  5'd7,  BYP ? 32'h1234 : 32'h9, BYP ? 32'h1234 : 32'h9, BYP ? 32'h1234 : 32'h9, 1'b0, 1'b0};
        tv[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  32'h1234, 32'h1234,              32'h1234,                      1'b0, 1'b0};
        tv[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 5'd31, BYP ? 32'hFFFFFFFF : 32'h0, 32'h0, BYP ? 32'hFFFFFFFF : 32'h0, 1'b0, 1'b0};
        tv[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  5'd31, 32'hFFFFFFFF, 32'hAA,            32'hFFFFFFFF,                  1'b0, 1'b0};

        rst = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
        read_addr = '0; read_addr4 = '0;

        // Reset state, then a write attempted one cycle into the clear.
        tick();
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_drop", {31'b0, write_drop}, 32'd0);
        chk("rst_read", read_data[0 +: DW], '0);
        rst = 1'b0;
        tick();
        write_en = 1'b1; write_addr = 5'd3; write_data = 32'h55;
        tick();
        write_en = 1'b0;
        chk("init_drop", {31'b0, write_drop}, 32'd1);
        chk("init_drop4", {31'b0, write_drop4}, 32'd1);
        tick();
        chk("init_drop_pulse", {31'b0, write_drop}, 32'd0);
        chk("init_ready_low", {31'b0, ready}, 32'd0);
        wait_ready(n);
        chk("clear_latency", n + 3, 32'd32);
        chk("ready4", {31'b0, ready4}, 32'd1);
        sweep_zero("clear1");

        // Table-driven run-mode vectors.
        tick();
        for (int i = 0; i < NV; i++) begin
            write_en   = tv[i].we;
            write_addr = tv[i].wa;
            write_data = tv[i].wd;
            read_addr  = {tv[i].ra1, tv[i].ra0};
            read_addr4 = {4{tv[i].ra4}};
            sb.push_back(tv[i]);
            @(negedge clk);
            cur = sb.pop_front();
            chk($sformatf("v%0d_rd0", i), read_data[0 +: DW], cur.e0);
            chk($sformatf("v%0d_rd1", i), read_data[DW +: DW], cur.e1);
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d_q%0d", i, k), read_data4[k*DW +: DW], cur.e4);
            tick();
            chk($sformatf("v%0d_drop", i), {31'b0, write_drop}, {31'b0, cur.edrop});
            chk($sformatf("v%0d_drop4", i), {31'b0, write_drop4}, {31'b0, cur.edrop4});
        end
        write_en = 1'b0;

        // Fill, reset mid-run, reset again mid-clear, then confirm a full clear.
        for (int a = 1; a < DEPTH; a++) begin
            write_en = 1'b1; write_addr = AW'(a); write_data = DW'(a);
            tick();
        end
        write_en = 1'b0;
        read_addr = {5'd31, 5'd1};
        #1;
        chk("fill_1", read_data[0 +: DW], 32'd1);
        chk("fill_31", read_data[DW +: DW], 32'd31);
        rst = 1'b1;
        tick();
        chk("midrun_ready", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        chk("midinit_ready", {31'b0, ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        chk("reclear_latency", n, 32'd32);
        sweep_zero("clear2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
